// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_W registers, byte-strobed bus writes,
// independent read path, hardware-side loads. Optional macro AXI_LITE_REGFILE_DECERR_EN.
module axi_lite_regfile #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse,
  input  logic [NUM_REGS-1:0]        hw_we,
  input  logic [NUM_REGS*DATA_W-1:0] hw_wdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_REGFILE_DECERR_EN
  localparam logic [1:0] RESP_ERR  = 2'b11;
`else
  localparam logic [1:0] RESP_ERR  = 2'b00;
`endif

  function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  logic                 rdy_q;
  logic                 aw_held_q, aw_held_d;
  logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
  logic                 w_held_q, w_held_d;
  logic [DATA_W-1:0]    w_data_q, w_data_d;
  logic [STRB_W-1:0]    w_strb_q, w_strb_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NUM_REGS-1:0]  wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0]    wr_data, rd_val;
  logic [STRB_W-1:0]    wr_strb;
  logic                 wr_in_range, rd_in_range;
  logic                 unused_addr_bits;

  // Readies stay low until the first edge after reset release.
  assign awready = rdy_q && !aw_held_q && !bvalid_q;
  assign wready  = rdy_q && !w_held_q && !bvalid_q;
  assign arready = rdy_q && !rvalid_q;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_idx  = aw_held_q ? aw_idx_q : awaddr[ADDR_W-1:OFF_W];
  assign wr_data = w_held_q ? w_data_q : wdata;
  assign wr_strb = w_held_q ? w_strb_q : wstrb;
  assign rd_idx  = araddr[ADDR_W-1:OFF_W];
  assign wr_in_range = ({1'b0, wr_idx} < NUM_REGS_L);
  assign rd_in_range = ({1'b0, rd_idx} < NUM_REGS_L);
  assign unused_addr_bits = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = regs_q[i];
    end
  end

  always_comb begin
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (rvalid_q && rready) rvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_ERR;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = awaddr[ADDR_W-1:OFF_W];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = wdata;
        w_strb_d = wstrb;
      end
    end

    // A committing bus write takes priority over a hardware load of the same register.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && wr_in_range && (wr_idx == IDX_W'(i))) begin
        regs_d[i]     = merge_strb(regs_q[i], wr_data, wr_strb);
        wr_pulse_d[i] = 1'b1;
      end else if (hw_we[i]) begin
        regs_d[i] = hw_wdata[i*DATA_W +: DATA_W];
      end
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_ERR;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdy_q      <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      rdy_q      <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign wr_pulse = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule
